// File: rtl/fsk_zc_demod_if.sv
// Sample-in / bit-out bundle of the 2FSK zero-crossing demodulator.
// master: din, din_valid out; dout, bit_valid, carrier_ok, vote_err in.
interface fsk_zc_demod_if #(
  parameter int DW = 11
) ();
  logic [DW-1:0] din;
  logic          din_valid;
  logic          dout;
  logic          bit_valid;
  logic          carrier_ok;
  logic          vote_err;

  modport master (
    output din, din_valid,
    input  dout, bit_valid, carrier_ok, vote_err
  );

  modport slave (
    input  din, din_valid,
    output dout, bit_valid, carrier_ok, vote_err
  );
endinterface

// File: rtl/fsk_zc_demod.sv
// 2FSK zero-crossing demodulator: half-period votes -> one bit per symbol.
// Ports: clk, rst_n (async low), bus (slave: din/din_valid in; dout,
// bit_valid, carrier_ok, vote_err out). Macro FSK_DEMOD_HYST_EN adds
// hysteresis of +/-HYST around MID to the polarity comparator.
module fsk_zc_demod #(
  parameter int DW       = 11,
  parameter int MID      = 1024,
  parameter int HYST     = 32,
  parameter int THRESH   = 384,
  parameter int BIT_LEN  = 2048,
  parameter int LOSS_LEN = 4096
) (
  input  logic           clk,
  input  logic           rst_n,
  fsk_zc_demod_if.slave  bus
);

`ifdef FSK_DEMOD_HYST_EN
  localparam int HW   = HYST;
  localparam int HI_T = MID + HW + 1;
`else
  // band collapses to a single comparator at MID
  localparam int HW   = 0 * HYST;
  localparam int HI_T = MID;
`endif
  localparam int LO_T = MID - HW;
  localparam int SW   = $clog2(BIT_LEN);
  localparam int LW   = $clog2(LOSS_LEN);
  localparam logic [11:0] IMAX = 12'hFFF;

  typedef enum logic {IDLE = 1'b0, TRACK = 1'b1} st_e;

  st_e            st_q, st_d;
  logic           vld;
  logic           pol_q, pol_d, pol_n;
  logic           crs, cross_q, cross_d;
  logic [11:0]    ivl_q, ivl_d;
  logic [LW-1:0]  sil_q, sil_d;
  logic [SW-1:0]  sym_q, sym_d;
  logic [7:0]     v0_q, v0_d, v1_q, v1_d;
  logic [7:0]     nv0, nv1;
  logic           dout_q, dout_d;
  logic           bv_q, bv_d;
  logic           err_q, err_d;
  logic           lock, loss, eos;

  assign vld = bus.din_valid;

  always_comb begin
    pol_n = pol_q;
    if (bus.din >= DW'(HI_T))
      pol_n = 1'b1;
    else if (bus.din < DW'(LO_T))
      pol_n = 1'b0;
  end

  assign crs     = vld && (pol_n != pol_q);
  assign pol_d   = vld ? pol_n : pol_q;
  // held across invalid cycles so lock waits for the next valid sample
  assign cross_d = vld ? crs : cross_q;

  assign lock = vld && (st_q == IDLE) && cross_q;
  assign loss = vld && (st_q == TRACK) && !crs
             && (sil_q == LW'(LOSS_LEN - 1));
  assign eos  = vld && (st_q == TRACK)
             && (sym_q == SW'(BIT_LEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_q <= IDLE;
    else        st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    unique case (1'b1)
      lock:    st_d = TRACK;
      loss:    st_d = IDLE;
      default: ;
    endcase
  end

  always_comb begin
    bus.carrier_ok = (st_q == TRACK);
    bus.dout       = dout_q;
    bus.bit_valid  = bv_q;
    bus.vote_err   = err_q;
  end

  // vote of the current sample's crossing (if any)
  always_comb begin
    nv0 = v0_q;
    nv1 = v1_q;
    if (crs) begin
      if (ivl_q < 12'(THRESH)) begin
        if (v1_q != 8'hFF) nv1 = v1_q + 8'd1;
      end else begin
        if (v0_q != 8'hFF) nv0 = v0_q + 8'd1;
      end
    end
  end

  always_comb begin
    ivl_d  = ivl_q;
    sil_d  = sil_q;
    sym_d  = sym_q;
    v0_d   = v0_q;
    v1_d   = v1_q;
    dout_d = dout_q;
    bv_d   = 1'b0;
    err_d  = 1'b0;
    if (vld) begin
      if (crs)
        ivl_d = 12'd1;
      else if (ivl_q != IMAX)
        ivl_d = ivl_q + 12'd1;
      if (lock || loss) begin
        sym_d = '0;
        v0_d  = '0;
        v1_d  = '0;
        sil_d = '0;
        if (lock) ivl_d = {11'd0, crs};
      end else if (st_q == TRACK) begin
        sil_d = crs ? '0 : sil_q + LW'(1);
        if (eos) begin
          sym_d = '0;
          v0_d  = '0;
          v1_d  = '0;
          bv_d  = 1'b1;
          if (nv1 > nv0)      dout_d = 1'b1;
          else if (nv0 > nv1) dout_d = 1'b0;
          else                err_d  = 1'b1;
        end else begin
          sym_d = sym_q + SW'(1);
          v0_d  = nv0;
          v1_d  = nv1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pol_q   <= 1'b0;
      cross_q <= 1'b0;
      ivl_q   <= '0;
      sil_q   <= '0;
      sym_q   <= '0;
      v0_q    <= '0;
      v1_q    <= '0;
      dout_q  <= 1'b0;
      bv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      pol_q   <= pol_d;
      cross_q <= cross_d;
      ivl_q   <= ivl_d;
      sil_q   <= sil_d;
      sym_q   <= sym_d;
      v0_q    <= v0_d;
      v1_q    <= v1_d;
      dout_q  <= dout_d;
      bv_q    <= bv_d;
      err_q   <= err_d;
    end
  end

endmodule
